note_display_ctrl: RTL and testbench
====================================

NOTE_DISPLAY_CTRL -- requirements
Module: note_display_ctrl

Interface
REQ-001 Parameter X_POS, default 8'd20, x origin of the 36x12 note glyph area.
REQ-002 Parameter Y_POS, default 7'd50, y origin of the glyph area.
REQ-003 Parameter HOLD_CYCLES, default 512, ld_note high time; SHALL be >= 440 (432-pixel clear plus margin).
REQ-004 Parameter DRAW_CYCLES, default 512, post-release draw time; SHALL be >= 440.
REQ-005 Parameter INIT_CYCLES, default 19328, post-reset wait covering the 160x120 screen clear.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 note_in  in  4  note code, 1..12 = A..G#.
REQ-009 octave_in  in  2  octave code 0..3.
REQ-010 note_valid  in  1  one-cycle strobe; note_in/octave_in sampled with it.
REQ-011 note  out  4  registered note code to the display stage.
REQ-012 octave  out  2  registered octave to the display stage.
REQ-013 ld_note  out  1  load/clear request to the display stage.
REQ-014 x  out  8  constant X_POS.
REQ-015 y  out  7  constant Y_POS.
REQ-016 colour  out  3  glyph colour derived from octave.
REQ-017 busy  out  1  high when state != IDLE.
REQ-018 fifo_full  out  1  request FIFO holds 4 entries.
REQ-019 drop  out  1  one-cycle pulse when a strobed request is discarded.

Function
REQ-020 Request FIFO SHALL be 4 entries x 6 bits, 2-bit pointers wrapping modulo 4, 3-bit count.
REQ-021 FSM states SHALL be INIT, IDLE, SETUP, LOAD, DRAW, driven by one 15-bit down-counter.
REQ-022 INIT: counter loads INIT_CYCLES-1 and decrements; at 0 go to IDLE.
REQ-023 IDLE: FIFO non-empty -> pop head, register note/octave/colour, go to SETUP; else stay.
REQ-024 SETUP: exactly one cycle, ld_note=0, so note/octave are stable one cycle before ld_note rises.
REQ-025 LOAD: ld_note=1 for exactly HOLD_CYCLES cycles, then DRAW.
REQ-026 DRAW: ld_note=0 for exactly DRAW_CYCLES cycles, then IDLE.
REQ-027 note/octave/colour SHALL stay constant from SETUP entry through DRAW exit.
REQ-028 Latency: strobe at edge t with FIFO empty and IDLE -> pop at edge t+1, ld_note high after edge t+2.
REQ-029 Colour map: octave 0->3'b100, 1->3'b010, 2->3'b001, 3->3'b111.
REQ-030 Strobe while FIFO full and no pop that cycle -> request dropped, drop=1 next cycle, FIFO unchanged.
REQ-031 Simultaneous strobe and pop when full -> both happen, count stays 4, no drop.
REQ-032 Strobe while FIFO empty and IDLE -> entry written, popped on the following edge (no bypass).
REQ-033 Strobes during INIT SHALL be queued, not dropped, subject to REQ-030.

Reset
REQ-034 reset=0 at any edge, including mid-LOAD or mid-DRAW -> state INIT, counter=INIT_CYCLES-1, FIFO emptied, pointers 0.
REQ-035 Reset values: note=0, octave=0, ld_note=0, colour=3'b000, busy=1, fifo_full=0, drop=0; x/y constant.
REQ-036 Strobes coinciding with reset=0 SHALL be ignored.

Configuration
REQ-037 Macro NOTE_DISP_FILTER_EN: when defined, strobes with note_in==0 or note_in>12 are discarded at input and drop pulses.
REQ-038 Without NOTE_DISP_FILTER_EN, every strobe is queued unchanged and invalid codes reach the display stage, which shows a blank letter.

Verification
REQ-039 Release reset, strobe note 5 oct 2 during INIT -> busy=1 for 19328 cycles, then note=5, octave=2, colour=001, ld_note high 512 cycles.
REQ-040 IDLE, strobe note 1 oct 0 at edge t -> ld_note rises after edge t+2, falls after t+514, busy falls after t+1026.
REQ-041 During LOAD, 6 strobes on consecutive cycles -> fifo_full after the 4th, drop pulses on the 5th and 6th, 4 requests displayed in order.
REQ-042 Full FIFO, strobe on the IDLE pop edge -> no drop, count remains 4.
REQ-043 reset=0 at cycle 100 of LOAD -> ld_note=0 next cycle, FIFO empty, INIT restarts from 19327.
REQ-044 With NOTE_DISP_FILTER_EN, strobe note 13 then note 0 -> two drop pulses, no ld_note; without the macro both are displayed in order.

Source files
------------

// File: rtl/note_display_ctrl.sv
// Note glyph display controller: queues note requests and sequences the display stage (clear/load, then draw).
// Optional macro NOTE_DISP_FILTER_EN discards strobes whose note code is outside 1..12.
module note_display_ctrl #(
    parameter logic [7:0] X_POS       = 8'd20,
    parameter logic [6:0] Y_POS       = 7'd50,
    parameter int         HOLD_CYCLES = 512,
    parameter int         DRAW_CYCLES = 512,
    parameter int         INIT_CYCLES = 19328
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    input  logic       note_valid,
    output logic [3:0] note,
    output logic [1:0] octave,
    output logic       ld_note,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       busy,
    output logic       fifo_full,
    output logic       drop
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETUP, S_LOAD, S_DRAW} state_t;

    localparam logic [14:0] INIT_LD = 15'(INIT_CYCLES - 1);
    localparam logic [14:0] HOLD_LD = 15'(HOLD_CYCLES - 1);
    localparam logic [14:0] DRAW_LD = 15'(DRAW_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [14:0] r_cnt, w_cnt_nxt;

    logic [5:0]  r_mem [4];
    logic [1:0]  r_wr_ptr, r_rd_ptr;
    logic [2:0]  r_count;
    logic [3:0]  r_note;
    logic [1:0]  r_octave;
    logic [2:0]  r_colour;
    logic        r_drop;

    logic        w_code_ok, w_pop, w_push, w_full;
    logic [5:0]  w_head;
    logic [2:0]  w_colour;

`ifdef NOTE_DISP_FILTER_EN
    assign w_code_ok = (note_in != 4'd0) && (note_in <= 4'd12);
`else
    assign w_code_ok = 1'b1;
`endif

    assign w_full = (r_count == 3'd4);
    assign w_head = r_mem[r_rd_ptr];
    assign w_pop  = (r_state == S_IDLE) && (r_count != 3'd0);
    // A pop on the same edge frees a slot, so a strobe into a full FIFO still lands.
    assign w_push = note_valid && w_code_ok && (!w_full || w_pop);

    always_comb begin
        w_colour = 3'b000;
        case (w_head[5:4])
            2'd0: w_colour = 3'b100;
            2'd1: w_colour = 3'b010;
            2'd2: w_colour = 3'b001;
            2'd3: w_colour = 3'b111;
            default: w_colour = 3'b000;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_INIT: begin
                if (r_cnt == 15'd0) w_state_nxt = S_IDLE;
                else                w_cnt_nxt   = r_cnt - 15'd1;
            end
            S_IDLE: begin
                if (w_pop) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                w_state_nxt = S_LOAD;
                w_cnt_nxt   = HOLD_LD;
            end
            S_LOAD: begin
                if (r_cnt == 15'd0) begin
                    w_state_nxt = S_DRAW;
                    w_cnt_nxt   = DRAW_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 15'd1;
                end
            end
            S_DRAW: begin
                if (r_cnt == 15'd0) w_state_nxt = S_IDLE;
                else                w_cnt_nxt   = r_cnt - 15'd1;
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = INIT_LD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_INIT;
            r_cnt    <= INIT_LD;
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_note   <= 4'd0;
            r_octave <= 2'd0;
            r_colour <= 3'b000;
            r_drop   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drop  <= note_valid && !w_push;
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
                r_note   <= w_head[3:0];
                r_octave <= w_head[5:4];
                r_colour <= w_colour;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) r_mem[r_wr_ptr] <= {octave_in, note_in};
    end

    assign note      = r_note;
    assign octave    = r_octave;
    assign colour    = r_colour;
    assign ld_note   = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign fifo_full = w_full;
    assign drop      = r_drop;
    assign x         = X_POS;
    assign y         = Y_POS;

endmodule

// File: tb/tb_note_display_ctrl.sv
// Randomized bench for note_display_ctrl against a timeline/queue reference model.
module tb_note_display_ctrl;
    localparam int HOLD = 512;
    localparam int DRAW = 512;
    localparam int INIT = 19328;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] note_in = 4'd0;
    logic [1:0] octave_in = 2'd0;
    logic       note_valid = 1'b0;
    logic [3:0] note;
    logic [1:0] octave;
    logic       ld_note;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy;
    logic       fifo_full;
    logic       drop;

    always #5 clk = ~clk;

    note_display_ctrl dut (
        .clk(clk), .reset(reset), .note_in(note_in), .octave_in(octave_in),
        .note_valid(note_valid), .note(note), .octave(octave), .ld_note(ld_note),
        .x(x), .y(y), .colour(colour), .busy(busy), .fifo_full(fifo_full), .drop(drop)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at edge", tag, got, exp);
        end
    endtask

    // Reference model: request queue plus edge timestamps of when the display is free.
    int         e = 0;
    int         free_at = 0;
    int         pop_edge = -100000;
    logic [5:0] q[$];
    logic [3:0] m_note = 0;
    logic [1:0] m_oct = 0;
    logic [2:0] m_col = 0;
    bit         m_drop = 0;
    bit         m_live = 0;
    int         burst = 0;

    function automatic bit code_ok(input logic [3:0] n);
`ifdef NOTE_DISP_FILTER_EN
        return (n >= 1) && (n <= 12);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [2:0] col_of(input logic [1:0] o);
        case (o)
            2'd0: return 3'b100;
            2'd1: return 3'b010;
            2'd2: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    task automatic model_step();
        logic [5:0] h;
        e++;
        if (!reset) begin
            q.delete();
            free_at  = e + INIT;
            pop_edge = -100000;
            m_note = 0; m_oct = 0; m_col = 0; m_drop = 0; m_live = 1;
            return;
        end
        m_drop = 0;
        if (e > free_at && q.size() > 0) begin
            h = q.pop_front();
            m_note = h[3:0]; m_oct = h[5:4]; m_col = col_of(h[5:4]);
            pop_edge = e;
            free_at  = e + 1 + HOLD + DRAW;
        end
        if (note_valid) begin
            if (code_ok(note_in) && q.size() < 4) q.push_back({octave_in, note_in});
            else m_drop = 1;
        end
    endtask

    task automatic check_all();
        if (!m_live) return;
        chk("busy", busy, e < free_at);
        chk("ld_note", ld_note, (e >= pop_edge + 1) && (e <= pop_edge + HOLD));
        chk("note", note, m_note);
        chk("octave", octave, m_oct);
        chk("colour", colour, m_col);
        chk("fifo_full", fifo_full, q.size() == 4);
        chk("drop", drop, m_drop);
        chk("x", x, 20);
        chk("y", y, 50);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        note_valid = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] n, input logic [1:0] o);
        note_in = n; octave_in = o; note_valid = 1'b1;
        cyc();
    endtask

    task automatic run(input int ncyc, input bit rnd);
        for (int i = 0; i < ncyc; i++) begin
            if (rnd) begin
                if (burst > 0) begin
                    note_valid = 1'b1; burst--;
                end else if ($urandom_range(0, 299) == 0) begin
                    note_valid = 1'b1; burst = $urandom_range(0, 5);
                end
                // Aim strobes at pop edges while the queue is full.
                if (e + 1 > free_at && q.size() == 4 && $urandom_range(0, 1) == 1) note_valid = 1'b1;
                if ($urandom_range(0, 7) == 0) note_in = 4'($urandom_range(0, 15));
                else note_in = 4'($urandom_range(1, 12));
                octave_in = 2'($urandom_range(0, 3));
            end
            cyc();
        end
    endtask

    initial begin
        // Reset, with a strobe that must be ignored.
        reset = 1'b0;
        cyc();
        strobe(4'd7, 2'd1);
        reset = 1'b1;
        // Strobe during INIT is queued and shown once INIT ends.
        strobe(4'd5, 2'd2);
        run(21000, 0);
        // Single request from IDLE.
        strobe(4'd1, 2'd0);
        run(1100, 0);
        // Out-of-range codes: dropped with the filter, displayed without.
        strobe(4'd13, 2'd3);
        strobe(4'd0, 2'd1);
        run(2200, 0);
        // Six back-to-back strobes while a display is in LOAD.
        strobe(4'd2, 2'd1);
        run(200, 0);
        for (int k = 0; k < 6; k++) begin
            note_in = 4'(3 + k); octave_in = 2'(k); note_valid = 1'b1;
            cyc();
        end
        run(5300, 0);
        run(15000, 1);
        // Reset 100 cycles into a LOAD phase.
        strobe(4'd9, 2'd3);
        begin
            int guard = 0;
            while (!(e - pop_edge == 100) && guard < 5000) begin
                cyc();
                guard++;
            end
            chk("load_wait", guard < 5000, 1);
        end
        reset = 1'b0;
        strobe(4'd4, 2'd0);
        reset = 1'b1;
        run(19400, 0);
        run(4000, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
